// File: rtl/olink_tx_framer_pkg.sv
// Shared types and constants for the optical link TX framer.
// Word widths, K-code bytes and the slot word-type encoding.
package olink_pkg;

    localparam int WORD_W = 32;
    localparam int K_W    = 4;
    localparam int LANE_W = 16;
    localparam int ENT_W  = WORD_W + K_W;

    localparam logic [7:0] K_COMMA = 8'hBC;
    localparam logic [7:0] K_IDLE  = 8'hF7;
    localparam logic [7:0] K_PAD   = 8'h1C;

    typedef enum logic [1:0] {
        W_COMMA,
        W_IDLE,
        W_DATA,
        W_PAD
    } wtype_e;

    typedef struct packed {
        logic [LANE_W-1:0] d;
        logic [1:0]        k;
    } half_t;

    localparam half_t HALF_IDLE = '{d: {K_IDLE, K_IDLE}, k: 2'b11};
    localparam half_t HALF_PAD  = '{d: {K_PAD, K_PAD}, k: 2'b11};

    function automatic logic k_legal(input logic [K_W-1:0] k);
        return (k == 4'h0) || (k == 4'hF);
    endfunction

endpackage

// File: rtl/olink_tx_framer_if.sv
// Ingress word handshake between fabric logic and the TX framer.
// Fabric drives the master side; the framer is the slave.
interface olink_tx_if;

    logic [olink_pkg::WORD_W-1:0] in_d;
    logic [olink_pkg::K_W-1:0]    in_k;
    logic                         in_valid;
    logic                         in_ready;

    modport master (
        output in_d,
        output in_k,
        output in_valid,
        input  in_ready
    );

    modport slave (
        input  in_d,
        input  in_k,
        input  in_valid,
        output in_ready
    );

endinterface

// File: rtl/olink_tx_framer_fifo.sv
// Ingress FIFO for {k,d} entries; ready is registered from next count.
// Full FIFO never accepts, even when the same edge pops.
module olink_tx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 36
) (
    input  logic             clk_link,
    input  logic             reset,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic             empty_o,
    output logic             ready_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q;
    logic [AW-1:0]    rd_q;
    logic [CW-1:0]    cnt_q;
    logic [CW-1:0]    cnt_d;
    logic             ready_q;
    logic             do_push;
    logic             do_pop;

    assign do_push = push_i && ready_q;
    assign do_pop  = pop_i && (cnt_q != '0);
    assign cnt_d   = cnt_q + CW'(do_push) - CW'(do_pop);

    always_ff @(posedge clk_link) begin
        if (do_push) mem_q[wr_q] <= data_i;
    end

    always_ff @(posedge clk_link) begin
        if (reset) begin
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            if (do_push) wr_q <= wr_q + AW'(1);
            if (do_pop)  rd_q <= rd_q + AW'(1);
            cnt_q   <= cnt_d;
            ready_q <= (cnt_d != CW'(DEPTH));
        end
    end

    assign data_o  = mem_q[rd_q];
    assign empty_o = (cnt_q == '0);
    assign ready_o = ready_q;

endmodule

// File: rtl/olink_tx_framer.sv
// TX framer: 32-bit words to 16-bit lane halves with commas/idles/pads.
// Slot selection, comma timer and status counters live here.
module olink_tx_framer
    import olink_pkg::*;
#(
    parameter int FIFO_DEPTH   = 4,
    parameter int COMMA_PERIOD = 256
) (
    input  logic        clk_link,
    input  logic        reset,
    input  logic        link_enable,
    input  logic        counter_clear,
    input  logic        force_comma,
    olink_tx_if.slave   in_if,
    output logic [15:0] tx_d,
    output logic [1:0]  tx_k,
    output logic        phase,
    output logic [7:0]  comma_seq,
    output logic [31:0] cnt_words,
    output logic [15:0] cnt_bad_k
);

    localparam int TW = $clog2(COMMA_PERIOD);

    logic [ENT_W-1:0] head;
    logic             empty;
    logic             ready;
    logic             slot;
    logic             comma_sel;
    logic             pop;
    wtype_e           wtype;
    half_t            lo;
    half_t            hi;

    logic          phase_q;
    half_t         tx_q;
    half_t         hold_q;
    logic [7:0]    seq_q;
    logic [TW-1:0] timer_q;
    logic          pend_q;
    logic [31:0]   words_q;
    logic [15:0]   bad_q;

    olink_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENT_W)
    ) u_fifo (
        .clk_link (clk_link),
        .reset    (reset),
        .push_i   (in_if.in_valid),
        .pop_i    (pop),
        .data_i   ({in_if.in_k, in_if.in_d}),
        .data_o   (head),
        .empty_o  (empty),
        .ready_o  (ready)
    );

    assign in_if.in_ready = ready;

    assign slot      = !phase_q;
    assign comma_sel = !link_enable || pend_q || force_comma
                     || (timer_q == TW'(COMMA_PERIOD - 1));

    always_comb begin
        if (comma_sel)                     wtype = W_COMMA;
        else if (empty)                    wtype = W_IDLE;
        else if (k_legal(head[ENT_W-1 -: K_W])) wtype = W_DATA;
        else                               wtype = W_PAD;
    end

    assign pop = slot && ((wtype == W_DATA) || (wtype == W_PAD));

    always_comb begin
        lo = HALF_IDLE;
        hi = HALF_IDLE;
        case (wtype)
            W_COMMA: lo = '{d: {seq_q + 8'd1, K_COMMA}, k: 2'b01};
            W_DATA: begin
                lo = '{d: head[15:0],  k: head[33:32]};
                hi = '{d: head[31:16], k: head[35:34]};
            end
            W_PAD: begin
                lo = HALF_PAD;
                hi = HALF_PAD;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_link) begin
        if (reset) begin
            phase_q <= 1'b0;
            tx_q    <= HALF_IDLE;
            hold_q  <= HALF_IDLE;
            seq_q   <= '0;
            timer_q <= '0;
            pend_q  <= 1'b1;
            words_q <= '0;
            bad_q   <= '0;
        end else begin
            phase_q <= !phase_q;
            if (slot) begin
                tx_q   <= lo;
                hold_q <= hi;
                if (wtype == W_COMMA) begin
                    seq_q   <= seq_q + 8'd1;
                    timer_q <= '0;
                    pend_q  <= 1'b0;
                end else begin
                    timer_q <= timer_q + TW'(1);
                end
            end else begin
                tx_q <= hold_q;
                if (force_comma) pend_q <= 1'b1;
            end
            // Clear takes priority over a same-edge increment.
            if (counter_clear) begin
                words_q <= '0;
                bad_q   <= '0;
            end else if (slot) begin
                if (wtype == W_DATA) words_q <= words_q + 32'd1;
                if (wtype == W_PAD && bad_q != 16'hFFFF) bad_q <= bad_q + 16'd1;
            end
        end
    end

    assign tx_d      = tx_q.d;
    assign tx_k      = tx_q.k;
    assign phase     = phase_q;
    assign comma_seq = seq_q;
    assign cnt_words = words_q;
    assign cnt_bad_k = bad_q;

endmodule

// File: tb/tb_olink_tx_framer.sv
// Randomised scoreboard bench for olink_tx_framer against a slot-level
// reference model built from word queues and plain counters.
module tb_olink_tx_framer;

    localparam int DEPTH = 4;
    localparam int CP    = 4;

    logic        clk_link = 1'b0;
    logic        reset = 1'b1;
    logic        link_enable = 1'b1;
    logic        counter_clear = 1'b0;
    logic        force_comma = 1'b0;
    logic [15:0] tx_d;
    logic [1:0]  tx_k;
    logic        phase;
    logic [7:0]  comma_seq;
    logic [31:0] cnt_words;
    logic [15:0] cnt_bad_k;

    olink_tx_if bus ();

    always #5 clk_link = ~clk_link;

    olink_tx_framer #(
        .FIFO_DEPTH   (DEPTH),
        .COMMA_PERIOD (CP)
    ) dut (
        .clk_link      (clk_link),
        .reset         (reset),
        .link_enable   (link_enable),
        .counter_clear (counter_clear),
        .force_comma   (force_comma),
        .in_if         (bus),
        .tx_d          (tx_d),
        .tx_k          (tx_k),
        .phase         (phase),
        .comma_seq     (comma_seq),
        .cnt_words     (cnt_words),
        .cnt_bad_k     (cnt_bad_k)
    );

    typedef struct {
        logic [17:0] tx;
        logic        ph;
        logic        rdy;
        logic [7:0]  seq;
        logic [31:0] words;
        logic [15:0] bad;
    } exp_t;

    exp_t        expq[$];
    logic [35:0] wq[$];

    logic        m_ph;
    logic        m_rdy;
    logic        m_pend;
    int          m_timer;
    logic [7:0]  m_seq;
    logic [31:0] m_words;
    logic [15:0] m_bad;
    logic [17:0] m_out;
    logic [17:0] m_hold;

    int checks = 0;
    int errors = 0;

    task automatic cmp(input string n, input logic [31:0] a,
                       input logic [31:0] x);
        checks++;
        if (a !== x) begin
            errors++;
            $display("FAIL %s got %h expected %h", n, a, x);
        end
    endtask

    // Reference model: one decision per two-cycle slot, FIFO as a queue.
    always @(posedge clk_link) begin
        logic [35:0] w;
        exp_t e;
        if (reset) begin
            wq.delete();
            m_ph = 0; m_rdy = 0; m_pend = 1; m_timer = 0; m_seq = 0;
            m_words = 0; m_bad = 0;
            m_out = {16'hF7F7, 2'b11};
            m_hold = {16'hF7F7, 2'b11};
        end else begin
            if (!m_ph) begin
                if (!link_enable || m_pend || force_comma || m_timer == CP - 1) begin
                    m_out = {m_seq + 8'd1, 8'hBC, 2'b01};
                    m_hold = {16'hF7F7, 2'b11};
                    m_seq++;
                    m_timer = 0;
                    m_pend = 0;
                end else if (wq.size() > 0) begin
                    w = wq.pop_front();
                    m_timer++;
                    if (w[35:32] == 4'h0 || w[35:32] == 4'hF) begin
                        m_out = {w[15:0], w[33:32]};
                        m_hold = {w[31:16], w[35:34]};
                        m_words++;
                    end else begin
                        m_out = {16'h1C1C, 2'b11};
                        m_hold = {16'h1C1C, 2'b11};
                        if (m_bad != 16'hFFFF) m_bad++;
                    end
                end else begin
                    m_out = {16'hF7F7, 2'b11};
                    m_hold = {16'hF7F7, 2'b11};
                    m_timer++;
                end
            end else begin
                m_out = m_hold;
                if (force_comma) m_pend = 1;
            end
            if (counter_clear) begin
                m_words = 0;
                m_bad = 0;
            end
            if (bus.in_valid && m_rdy) wq.push_back({bus.in_k, bus.in_d});
            m_rdy = (wq.size() < DEPTH);
            m_ph = !m_ph;
        end
        e.tx = m_out; e.ph = m_ph; e.rdy = m_rdy; e.seq = m_seq;
        e.words = m_words; e.bad = m_bad;
        expq.push_back(e);
    end

    // Monitor: compare every registered output against the model.
    always @(negedge clk_link) begin
        exp_t e;
        if (expq.size() > 0) begin
            e = expq.pop_front();
            cmp("tx", {14'd0, tx_d, tx_k}, {14'd0, e.tx});
            cmp("phase", {31'd0, phase}, {31'd0, e.ph});
            cmp("in_ready", {31'd0, bus.in_ready}, {31'd0, e.rdy});
            cmp("comma_seq", {24'd0, comma_seq}, {24'd0, e.seq});
            cmp("cnt_words", cnt_words, e.words);
            cmp("cnt_bad_k", {16'd0, cnt_bad_k}, {16'd0, e.bad});
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk_link);
    endtask

    task automatic wait_phase1();
        for (int i = 0; i < 4 && !m_ph; i++) cyc(1);
        cmp("phase1_wait", {31'd0, m_ph}, 32'd1);
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && wq.size() > 0; i++) cyc(1);
        cmp("drain", wq.size(), 0);
    endtask

    initial begin
        int r;
        bus.in_valid = 0;
        bus.in_d = '0;
        bus.in_k = '0;
        cyc(3);
        cmp("rst_tx_d", {16'd0, tx_d}, 32'hF7F7);
        reset = 0;
        cyc(1);
        cmp("first_comma_d", {16'd0, tx_d}, 32'h01BC);
        cmp("first_comma_k", {30'd0, tx_k}, 32'd1);
        cyc(1);
        cmp("first_comma_hi", {16'd0, tx_d}, 32'hF7F7);
        cyc(20);

        bus.in_valid = 1;
        bus.in_d = 32'hDEADBEEF;
        bus.in_k = 4'h0;
        cyc(1);
        bus.in_valid = 0;
        cyc(8);
        cmp("deadbeef_cnt", cnt_words, 32'd1);

        for (int i = 0; i < 400; i++) begin
            r = int'($urandom_range(0, 9));
            bus.in_valid = ($urandom_range(0, 9) < 8);
            bus.in_d = $urandom;
            bus.in_k = (r < 4) ? 4'h0 : (r < 8) ? 4'hF : 4'($urandom);
            force_comma = ($urandom_range(0, 29) == 0);
            counter_clear = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 49) == 0) link_enable = !link_enable;
            cyc(1);
        end
        bus.in_valid = 0;
        force_comma = 0;
        counter_clear = 0;
        link_enable = 1;
        drain();

        counter_clear = 1;
        cyc(1);
        counter_clear = 0;
        bus.in_valid = 1;
        bus.in_d = 32'h12345678;
        bus.in_k = 4'b0011;
        cyc(1);
        bus.in_valid = 0;
        cyc(8);
        cmp("bad_k_cnt", {16'd0, cnt_bad_k}, 32'd1);
        cmp("bad_k_words", cnt_words, 32'd0);

        link_enable = 0;
        bus.in_valid = 1;
        for (int i = 0; i < 8; i++) begin
            bus.in_d = $urandom;
            bus.in_k = 4'hF;
            cyc(1);
        end
        cmp("full_ready", {31'd0, bus.in_ready}, 32'd0);
        link_enable = 1;
        cyc(12);
        bus.in_valid = 0;
        drain();

        wait_phase1();
        force_comma = 1;
        cyc(2);
        force_comma = 0;
        cyc(10);

        bus.in_valid = 1;
        bus.in_d = 32'hCAFEF00D;
        bus.in_k = 4'h0;
        cyc(1);
        wait_phase1();
        reset = 1;
        counter_clear = 1;
        cyc(1);
        reset = 0;
        counter_clear = 0;
        bus.in_valid = 0;
        cmp("rst_mid_d", {16'd0, tx_d}, 32'hF7F7);
        cmp("rst_mid_k", {30'd0, tx_k}, 32'd3);
        cmp("rst_mid_words", cnt_words, 32'd0);
        cyc(1);
        cmp("rst_comma_d", {16'd0, tx_d}, 32'h01BC);
        cyc(20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
